// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 size codes,
// FSM state type, parameter defaults and the lane/extension helpers.
package dmem_pkg;

  localparam int DEFAULT_DEPTH_WORDS = 1024;
  localparam int DEFAULT_LATENCY     = 2;

  // RV32I load/store size codes (stores use only B/H/W)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Codes with no meaning for the given direction
  function automatic logic funct3_invalid(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: funct3_invalid = 1'b0;
      F3_BU, F3_HU:     funct3_invalid = we;
      default:          funct3_invalid = 1'b1;
    endcase
  endfunction

  // Halfword needs addr[0]==0, word needs addr[1:0]==0
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: is_misaligned = off[0];
      F3_W:        is_misaligned = |off;
      default:     is_misaligned = 1'b0;
    endcase
  endfunction

  // Silently round the byte offset down to the access size
  function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: align_off = {off[1], 1'b0};
      F3_W:        align_off = 2'b00;
      default:     align_off = off;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B:    store_be = 4'b0001 << off;
      F3_H:    store_be = off[1] ? 4'b1100 : 4'b0011;
      F3_W:    store_be = 4'b1111;
      default: store_be = 4'b0000;
    endcase
  endfunction

  // Replicate right-aligned store data across every lane it could land in
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wdata);
    case (f3)
      F3_B:    store_lanes = {4{wdata[7:0]}};
      F3_H:    store_lanes = {2{wdata[15:0]}};
      default: store_lanes = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [31:0] word,
                                               input logic [1:0] off);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      F3_B:    load_extract = {{24{sh[7]}}, sh[7:0]};
      F3_H:    load_extract = {{16{sh[15]}}, sh[15:0]};
      F3_W:    load_extract = word;
      F3_BU:   load_extract = {24'h0, sh[7:0]};
      F3_HU:   load_extract = {16'h0, sh[15:0]};
      default: load_extract = 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core <-> data-memory request/response channel.
// master = core side, slave = responder side.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_array.sv
// Word-organised storage: synchronous byte-enabled write, combinational read.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           i_we,
  input  logic [3:0]                     i_be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
  input  logic [31:0]                    i_wdata,
  output logic [31:0]                    o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // Byte-lane write of the addressed word
  // NOTE: storage is deliberately left out of reset so it maps onto plain RAM;
  // state registers use <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency RV32I data-memory responder.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned halfword/word accesses
// fault instead of being silently aligned.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int LATENCY     = DEFAULT_LATENCY
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t       r_state, w_next_state;
  logic [3:0]   r_cnt, w_next_cnt;

  logic         r_we;
  logic [AW+1:0] r_addr;
  logic [31:0]  r_wdata;
  logic [2:0]   r_funct3;
  logic [31:0]  r_resp_rdata;
  logic         r_resp_err;

  logic         w_accept;
  logic         w_go_resp;
  logic         w_we;
  logic [AW+1:0] w_addr;
  logic [31:0]  w_wdata;
  logic [2:0]   w_f3;
  logic [1:0]   w_off;
  logic         w_misalign;
  logic         w_err;
  logic         w_wr_en;
  logic [3:0]   w_be;
  logic [31:0]  w_rd_word;
  logic         w_unused_addr;

  // Address bits above the storage range wrap and are not used
  assign w_unused_addr = ^bus.req_addr[31:AW+2];

  assign w_accept = bus.req_valid && (r_state == ST_IDLE);

  // The transition into RESP is the accept edge itself when LATENCY==1, so
  // in IDLE the access uses the live request, otherwise the latched one.
  assign w_we    = (r_state == ST_IDLE) ? bus.req_we              : r_we;
  assign w_addr  = (r_state == ST_IDLE) ? bus.req_addr[AW+1:0]    : r_addr;
  assign w_wdata = (r_state == ST_IDLE) ? bus.req_wdata           : r_wdata;
  assign w_f3    = (r_state == ST_IDLE) ? bus.req_funct3          : r_funct3;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_misalign = is_misaligned(w_f3, w_addr[1:0]);
  assign w_off      = w_addr[1:0];
`else
  assign w_misalign = 1'b0;
  assign w_off      = align_off(w_f3, w_addr[1:0]);
`endif

  assign w_err     = funct3_invalid(w_we, w_f3) || w_misalign;
  assign w_be      = store_be(w_f3, w_off);
  assign w_go_resp = (w_next_state == ST_RESP) && (r_state != ST_RESP);
  // A store in flight when reset hits must not reach storage
  assign w_wr_en   = w_go_resp && w_we && !w_err && !rst;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_be    (w_be),
    .i_addr  (w_addr[AW+1:2]),
    .i_wdata (store_lanes(w_f3, w_wdata)),
    .o_rdata (w_rd_word)
  );

  // Next-state and latency counter
  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_cnt   = CNT_LOAD;
          w_next_state = (LATENCY == 1) ? ST_RESP : ST_BUSY;
        end
      end
      ST_BUSY: begin
        w_next_cnt = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
        if (r_cnt <= 4'd1) w_next_state = ST_RESP;
      end
      ST_RESP: begin
        if (bus.resp_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Capture the request on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= 32'h0;
      r_funct3 <= 3'b000;
    end else if (w_accept) begin
      r_we     <= bus.req_we;
      r_addr   <= bus.req_addr[AW+1:0];
      r_wdata  <= bus.req_wdata;
      r_funct3 <= bus.req_funct3;
    end
  end

  // Response data/err, held until the next access completes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_rdata <= 32'h0;
      r_resp_err   <= 1'b0;
    end else if (w_go_resp) begin
      r_resp_err   <= w_err;
      r_resp_rdata <= (w_we || w_err) ? 32'h0 : load_extract(w_f3, w_rd_word, w_off);
    end
  end

  assign bus.req_ready  = (r_state == ST_IDLE);
  assign bus.resp_valid = (r_state == ST_RESP);
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=2 / 1024-word instance and
// a LATENCY=1 / 16-word instance sharing one stimulus driver.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if bus0 ();
  dmem_responder_if bus1 ();

  logic        tb_valid  = 1'b0;
  logic        tb_we     = 1'b0;
  logic        tb_rready = 1'b1;
  logic [31:0] tb_addr   = 32'h0;
  logic [31:0] tb_wdata  = 32'h0;
  logic [2:0]  tb_f3     = 3'b000;
  int          sel       = 0;

  assign bus0.req_valid  = tb_valid && (sel == 0);
  assign bus0.req_we     = tb_we;
  assign bus0.req_addr   = tb_addr;
  assign bus0.req_wdata  = tb_wdata;
  assign bus0.req_funct3 = tb_f3;
  assign bus0.resp_ready = tb_rready;
  assign bus1.req_valid  = tb_valid && (sel == 1);
  assign bus1.req_we     = tb_we;
  assign bus1.req_addr   = tb_addr;
  assign bus1.req_wdata  = tb_wdata;
  assign bus1.req_funct3 = tb_f3;
  assign bus1.resp_ready = tb_rready;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut (
    .clk (clk), .rst (rst), .bus (bus0)
  );
  dmem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) u_dut_l1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  logic        obs_ready, obs_valid, obs_err;
  logic [31:0] obs_rdata;
  assign obs_ready = sel ? bus1.req_ready  : bus0.req_ready;
  assign obs_valid = sel ? bus1.resp_valid : bus0.resp_valid;
  assign obs_err   = sel ? bus1.resp_err   : bus0.resp_err;
  assign obs_rdata = sel ? bus1.resp_rdata : bus0.resp_rdata;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m0 [1024];
  logic [31:0] m1 [16];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          lat      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference memory model: byte-by-byte, independent of the lane helpers
  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, output exp_t e);
    int          nbytes;
    bit          sgn;
    bit          bad;
    logic [1:0]  o;
    logic [31:0] word;
    logic [31:0] v;
    int          idx;
    o = addr[1:0]; bad = 0; sgn = 0; nbytes = 0;
    case (f3)
      3'd0:    begin nbytes = 1; sgn = 1; end
      3'd1:    begin nbytes = 2; sgn = 1; end
      3'd2:    nbytes = 4;
      3'd4:    begin nbytes = 1; bad = we; end
      3'd5:    begin nbytes = 2; bad = we; end
      default: bad = 1;
    endcase
    if (!bad) begin
`ifdef DMEM_MISALIGN_TRAP_EN
      if ((nbytes == 2 && o[0]) || (nbytes == 4 && o != 2'b00)) bad = 1;
`else
      if (nbytes == 2) o[0] = 1'b0;
      if (nbytes == 4) o = 2'b00;
`endif
    end
    e.err   = bad;
    e.rdata = 32'h0;
    if (!bad) begin
      idx  = sel ? int'(addr[5:2]) : int'(addr[11:2]);
      word = sel ? m1[idx] : m0[idx];
      if (we) begin
        for (int i = 0; i < nbytes; i++) word[8*(int'(o)+i) +: 8] = wdata[8*i +: 8];
        if (sel) m1[idx] = word;
        else     m0[idx] = word;
      end else begin
        v = 32'h0;
        for (int i = 0; i < nbytes; i++) v[8*i +: 8] = word[8*(int'(o)+i) +: 8];
        if (sgn && v[8*nbytes-1]) begin
          for (int k = 8*nbytes; k < 32; k++) v[k] = 1'b1;
        end
        e.rdata = v;
      end
    end
  endtask

  // Drive one request, return #1 after its accept edge with expectation queued
  task automatic send(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] f3);
    int   guard;
    logic rdy;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (!obs_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    tb_we = we; tb_addr = addr; tb_wdata = wdata; tb_f3 = f3; tb_valid = 1'b1;
    #4 rdy = obs_ready;
    @(posedge clk);
    #1 tb_valid = 1'b0;
    check({tag, "/ready"}, rdy, 1);
    model(we, addr, wdata, f3, e);
    sb.push_back(e);
    lat = 1;
  endtask

  task automatic wait_resp(input string tag, output exp_t e);
    while (!obs_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    check({tag, "/latency"}, lat, sel ? 1 : 2);
    e = sb.pop_front();
    check({tag, "/rdata"}, obs_rdata, e.rdata);
    check({tag, "/err"}, obs_err, e.err);
  endtask

  task automatic finish_resp(input string tag);
    tb_rready = 1'b1;
    @(posedge clk);
    #1 check({tag, "/resp_drop"}, obs_valid, 0);
  endtask

  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [2:0] f3);
    exp_t e;
    send(tag, we, addr, wdata, f3);
    wait_resp(tag, e);
    finish_resp(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        e;
    logic [31:0] saved;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst/resp_valid", obs_valid, 0);
    check("rst/rdata", obs_rdata, 0);
    check("rst/err", obs_err, 0);
    rst = 1'b0;
    @(posedge clk);
    #1 check("rst/req_ready", obs_ready, 1);

    // Word store/load round trip
    txn("sw10", 1, 32'h10, 32'hDEADBEEF, F3_W);
    txn("lw10", 0, 32'h10, 32'h0, F3_W);

    // Byte store and sign/zero-extended loads
    txn("sw10z", 1, 32'h10, 32'h0, F3_W);
    txn("sb13", 1, 32'h13, 32'h80, F3_B);
    txn("lb13", 0, 32'h13, 32'h0, F3_B);
    txn("lbu13", 0, 32'h13, 32'h0, F3_BU);
    txn("lw10b", 0, 32'h10, 32'h0, F3_W);

    // Halfword lanes
    txn("sw14", 1, 32'h14, 32'h11223344, F3_W);
    txn("sh16", 1, 32'h16, 32'hFFFFBEEF, F3_H);
    txn("lh16", 0, 32'h16, 32'h0, F3_H);
    txn("lhu14", 0, 32'h14, 32'h0, F3_HU);
    txn("lb15", 0, 32'h15, 32'h0, F3_B);

    // Misaligned accesses (trap or forced alignment depending on build)
    txn("lw12", 0, 32'h12, 32'h0, F3_W);
    txn("sh11", 1, 32'h11, 32'h7777, F3_H);
    txn("lw10c", 0, 32'h10, 32'h0, F3_W);

    // Response back-pressure; a request held meanwhile must be ignored
    tb_rready = 1'b0;
    send("stall", 0, 32'h14, 32'h0, F3_W);
    wait_resp("stall", e);
    tb_we = 1'b1; tb_addr = 32'h14; tb_wdata = 32'h55555555; tb_f3 = F3_W; tb_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("stall/valid", obs_valid, 1);
      check("stall/rdata", obs_rdata, e.rdata);
      check("stall/req_ready", obs_ready, 0);
    end
    tb_valid = 1'b0;
    finish_resp("stall");
    txn("lw14_after_stall", 0, 32'h14, 32'h0, F3_W);

    // Invalid funct3 codes
    txn("f3_011", 0, 32'h14, 32'h0, 3'b011);
    txn("f3_111", 0, 32'h14, 32'h0, 3'b111);
    txn("sbu_store", 1, 32'h14, 32'hAAAAAAAA, 3'b100);
    txn("lw14_after_bad", 0, 32'h14, 32'h0, F3_W);

    // Reset while a store is in BUSY
    txn("sw20", 1, 32'h20, 32'hCAFEF00D, F3_W);
    txn("lw20", 0, 32'h20, 32'h0, F3_W);
    saved = m0[8];
    send("sw20_rst", 1, 32'h20, 32'h1234, F3_W);
    m0[8] = saved;
    void'(sb.pop_front());
    check("busy/req_ready", obs_ready, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst/resp_valid", obs_valid, 0);
    check("midrst/rdata", obs_rdata, 0);
    check("midrst/err", obs_err, 0);
    rst = 1'b0;
    @(posedge clk);
    #1 check("midrst/req_ready", obs_ready, 1);
    txn("lw20_after_rst", 0, 32'h20, 32'h0, F3_W);

    // Address wrap modulo depth
    txn("lw_wrap", 0, 32'h1010, 32'h0, F3_W);

    // Random mix over a pre-initialised window
    for (int w = 0; w < 16; w++) txn("rinit", 1, 32'h40 + 32'(4*w), $urandom, F3_W);
    for (int n = 0; n < 30; n++) begin
      txn("rand", 1'($urandom_range(0, 1)), 32'h40 + 32'($urandom_range(0, 63)),
          $urandom, 3'($urandom_range(0, 7)));
    end

    // LATENCY=1, 16-word instance
    sel = 1;
    txn("l1_sw4", 1, 32'h4, 32'hA5A50001, F3_W);
    txn("l1_lw44", 0, 32'h44, 32'h0, F3_W);
    txn("l1_lb7", 0, 32'h7, 32'h0, F3_B);
    txn("l1_sh6", 1, 32'h6, 32'h00009876, F3_H);
    txn("l1_lhu6", 0, 32'h6, 32'h0, F3_HU);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, storage size in 32-bit words (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request accept to resp_valid (legal 1..15).
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  in  1  core request present.
REQ-006 SHALL have port req_ready  out  1  responder can accept a request.
REQ-007 SHALL have port req_we  in  1  1=store, 0=load.
REQ-008 SHALL have port req_addr  in  32  byte address.
REQ-009 SHALL have port req_wdata  in  32  store data, right-aligned (rs2_data).
REQ-010 SHALL have port req_funct3  in  3  RV32I size/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-011 SHALL have port resp_valid  out  1  response present.
REQ-012 SHALL have port resp_ready  in  1  core accepts response.
REQ-013 SHALL have port resp_rdata  out  32  load data, extended per funct3; 0 for stores.
REQ-014 SHALL have port resp_err  out  1  request faulted; no architectural effect.

Function
REQ-015 SHALL implement FSM IDLE, BUSY, RESP; req_ready = (state==IDLE).
REQ-016 SHALL accept a request on req_valid && req_ready, latching we/addr/wdata/funct3, and load latency counter with LATENCY-1.
REQ-017 SHALL go IDLE->RESP directly when LATENCY==1, else IDLE->BUSY, decrementing once per cycle, BUSY->RESP when counter reaches 0.
REQ-018 SHALL assert resp_valid exactly LATENCY cycles after the accept edge.
REQ-019 SHALL hold resp_valid, resp_rdata, resp_err stable in RESP until resp_valid && resp_ready; then go to IDLE (one idle cycle, no back-to-back accept).
REQ-020 SHALL index storage with req_addr[log2(DEPTH_WORDS)+1:2]; upper address bits ignored (wrap modulo DEPTH_WORDS).
REQ-021 SHALL perform stores once, on the BUSY/IDLE->RESP transition edge, with byte enables: SB one lane by addr[1:0], SH two lanes by addr[1], SW all four.
REQ-022 SHALL return loads from word read at the same transition: LB/LH sign-extend, LBU/LHU zero-extend, LW as-is, lane selected by addr[1:0].
REQ-023 SHALL treat funct3 011, 110, 111 (and 100/101 on store) as invalid: resp_err=1, rdata=0, no write.
REQ-024 SHALL ignore req_valid while not IDLE; requests are never dropped because req_ready is low.

Reset
REQ-025 SHALL on rst force state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0; req_ready 1 the cycle after rst deasserts.
REQ-026 SHALL discard an in-flight request on rst; a store not yet written SHALL NOT modify storage.
REQ-027 SHALL NOT reset storage contents.

Configuration
REQ-028 SHALL with DMEM_MISALIGN_TRAP_EN defined flag halfword at addr[0]=1 or word at addr[1:0]!=0 as resp_err=1, rdata=0, no write.
REQ-029 SHALL without DMEM_MISALIGN_TRAP_EN force alignment (clear addr[0] for halfword, addr[1:0] for word) with resp_err only for invalid funct3.

Structure
REQ-030 SHALL place funct3 code constants, FSM state typedef, and DEPTH/LATENCY defaults in shared package dmem_pkg.
REQ-031 SHALL instantiate one sub-module dmem_array: synchronous word storage with 4-bit byte write enable and combinational read.

Verification
REQ-032 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rdata 0xDEADBEEF, resp_valid exactly 2 cycles after each accept (LATENCY=2).
REQ-033 SB 0x13 data 0x80 over 0x00000000, LB 0x13 -> 0xFFFFFF80, LBU 0x13 -> 0x00000080, LW 0x10 -> 0x80000000.
REQ-034 LW issued, resp_ready low 5 cycles -> resp_valid/rdata stable 5 cycles, req_ready 0 throughout; new req_valid ignored.
REQ-035 LW 0x12: with DMEM_MISALIGN_TRAP_EN -> resp_err 1, rdata 0; without -> reads word 0x10, resp_err 0.
REQ-036 SW 0x20 data 0x1234, rst pulsed in BUSY -> all outputs 0, later LW 0x20 returns prior content; funct3=011 -> resp_err 1.
REQ-037 LW at 4*DEPTH_WORDS+0x10 -> returns word 0x10 (wrap); LATENCY=1 build -> resp_valid 1 cycle after accept.
